// File: rtl/div_pkg.sv
// Shared types and constants for the EX-stage divide sequencer.
package div_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam logic [XLEN_DEFAULT-1:0] INT_MIN = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_ADJUST,
      ST_DONE
   } div_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage divide request/response bundle; master is the pipeline, slave is the sequencer.
interface div_sequencer_if #(parameter int XLEN = div_pkg::XLEN_DEFAULT);
   import div_pkg::*;

   logic            start_e;
   div_op_t         div_op;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            flush_e;
   logic            stall_req;
   logic            busy;
   logic [XLEN-1:0] result;
   logic            result_valid;

   modport master (
      output start_e, div_op, src_a, src_b, flush_e,
      input  stall_req, busy, result, result_valid
   );

   modport slave (
      input  start_e, div_op, src_a, src_b, flush_e,
      output stall_req, busy, result, result_valid
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the dividend MSB, trial-subtract the divisor.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] dividend_next,
   output logic            q_bit
);

   logic [XLEN:0]   rem_shift;
   logic [XLEN-1:0] diff;
   logic            borrow;

   assign rem_shift         = {rem, dividend[XLEN-1]};
   assign {borrow, diff}    = {1'b0, rem_shift[XLEN-1:0]} - {1'b0, divisor};
   // A set top bit means rem_shift already exceeds any XLEN-bit divisor.
   assign q_bit             = rem_shift[XLEN] | ~borrow;
   assign rem_next          = q_bit ? diff : rem_shift[XLEN-1:0];
   assign dividend_next     = {dividend[XLEN-2:0], 1'b0};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller with pipeline stall request.
// Optional last-result cache enabled by defining DIV_OPERAND_CACHE_EN.
//
// state     | meaning
// ST_IDLE   | waiting for start_e; special cases / cache hits resolve here
// ST_CALC   | one restoring iteration per cycle, counter XLEN-1 down to 0
// ST_ADJUST | apply signs and select quotient or remainder
// ST_DONE   | result_valid pulse, back to idle
module div_sequencer
   import div_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = $clog2(XLEN)
) (
   input logic          clk,
   input logic          rst_n,
   div_sequencer_if.slave bus
);

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t      state_q, state_d;
   div_op_t         op_q;
   logic            neg_a_q, neg_b_q;
   logic [XLEN-1:0] dvd_q, dvs_q, rem_q, result_q;
   logic [CNT_W-1:0] cnt_q;

   logic            signed_op, sign_a, sign_b, div_zero, overflow, special;
   logic [XLEN-1:0] abs_a, abs_b, special_res, fast_res;
   logic [XLEN-1:0] step_rem, step_dvd, adj_q, adj_r, adj_res;
   logic            step_q, cache_hit;
   logic [XLEN-1:0] cache_res;

   assign signed_op   = ~bus.div_op[0];
   assign sign_a      = signed_op & bus.src_a[XLEN-1];
   assign sign_b      = signed_op & bus.src_b[XLEN-1];
   assign abs_a       = sign_a ? -bus.src_a : bus.src_a;
   assign abs_b       = sign_b ? -bus.src_b : bus.src_b;
   assign div_zero    = (bus.src_b == '0);
   assign overflow    = signed_op && (bus.src_a == MIN_VAL) && (bus.src_b == '1);
   assign special     = div_zero | overflow;
   assign special_res = (bus.div_op inside {OP_REM, OP_REMU}) ?
                        (div_zero ? bus.src_a : '0) :
                        (div_zero ? '1 : MIN_VAL);
   assign fast_res    = special ? special_res : cache_res;

   assign adj_q   = (neg_a_q ^ neg_b_q) ? -dvd_q : dvd_q;
   assign adj_r   = neg_a_q ? -rem_q : rem_q;
   assign adj_res = (op_q inside {OP_REM, OP_REMU}) ? adj_r : adj_q;

   div_step #(.XLEN(XLEN)) u_step (
      .rem           (rem_q),
      .dividend      (dvd_q),
      .divisor       (dvs_q),
      .rem_next      (step_rem),
      .dividend_next (step_dvd),
      .q_bit         (step_q)
   );

`ifdef DIV_OPERAND_CACHE_EN
   logic            cache_valid, cache_signed;
   logic [XLEN-1:0] op_a_q, op_b_q, cache_a, cache_b, cache_q, cache_r;

   assign cache_hit = cache_valid && (cache_a == bus.src_a) && (cache_b == bus.src_b) &&
                      (cache_signed == signed_op);
   assign cache_res = (bus.div_op inside {OP_REM, OP_REMU}) ? cache_r : cache_q;

   // Only completed full-length operations populate the cache; flush never clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid  <= 1'b0;
         cache_signed <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         cache_a      <= '0;
         cache_b      <= '0;
         cache_q      <= '0;
         cache_r      <= '0;
      end else if (!bus.flush_e) begin
         if (state_q == ST_IDLE && bus.start_e) begin
            op_a_q <= bus.src_a;
            op_b_q <= bus.src_b;
         end
         if (state_q == ST_ADJUST) begin
            cache_valid  <= 1'b1;
            cache_signed <= ~op_q[0];
            cache_a      <= op_a_q;
            cache_b      <= op_b_q;
            cache_q      <= adj_q;
            cache_r      <= adj_r;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
   assign cache_res = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush_e) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:   if (bus.start_e) state_d = (special | cache_hit) ? ST_DONE : ST_CALC;
            ST_CALC:   if (cnt_q == '0) state_d = ST_ADJUST;
            ST_ADJUST: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy         = (state_q != ST_IDLE);
      bus.result_valid = (state_q == ST_DONE) && !bus.flush_e;
      bus.stall_req    = bus.start_e & ~bus.result_valid;
      bus.result       = result_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_DIV;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (!bus.flush_e) begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start_e) begin
                  op_q    <= bus.div_op;
                  neg_a_q <= sign_a;
                  neg_b_q <= sign_b;
                  dvd_q   <= abs_a;
                  dvs_q   <= abs_b;
                  if (special | cache_hit) begin
                     result_q <= fast_res;
                  end else begin
                     rem_q <= '0;
                     cnt_q <= CNT_W'(XLEN-1);
                  end
               end
            end
            ST_CALC: begin
               rem_q <= step_rem;
               dvd_q <= step_dvd | {{(XLEN-1){1'b0}}, step_q};
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end
            ST_ADJUST: result_q <= adj_res;
            default: ;
         endcase
      end
   end

   // The pipeline must hold the op in EX until the result or a flush arrives.
   a_start_held: assert property (@(posedge clk) disable iff (!rst_n)
      ((state_q == ST_CALC || state_q == ST_ADJUST) && !bus.flush_e) |-> bus.start_e);

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table plus flush, reset, back-to-back and cache sequences.
module tb_div_sequencer;
   import div_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_sequencer_if #(.XLEN(32)) dif();

   div_sequencer #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   int checks = 0;
   int errors = 0;

`ifdef DIV_OPERAND_CACHE_EN
   localparam int REPEAT_LAT = 1;
`else
   localparam int REPEAT_LAT = 34;
`endif

   typedef struct {
      string       name;
      div_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Issues an op at the next cycle and leaves start_e high through the DONE cycle.
   task automatic run_op(input string name, input div_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int seen;
      int k;
      int bad_stall;
      seen = 0;
      k = 0;
      bad_stall = 0;
      @(posedge clk); #1;
      dif.start_e = 1'b1;
      dif.div_op  = op;
      dif.src_a   = a;
      dif.src_b   = b;
      while (seen == 0 && k <= 40) begin
         @(negedge clk);
         if (dif.result_valid === 1'b1) begin
            seen = 1;
            if (dif.stall_req !== 1'b0) bad_stall++;
         end else begin
            if (dif.stall_req !== 1'b1) bad_stall++;
            k++;
         end
      end
      check({name, " valid"}, seen, 1);
      check({name, " latency"}, k, lat);
      check({name, " result"}, dif.result, exp);
      check({name, " stall"}, bad_stall, 0);
   endtask

   task automatic end_op(input string name, input logic [31:0] exp);
      @(posedge clk); #1;
      dif.start_e = 1'b0;
      @(negedge clk);
      check({name, " pulse_width"}, dif.result_valid, 0);
      check({name, " idle"}, dif.busy, 0);
      check({name, " result_hold"}, dif.result, exp);
   endtask

   task automatic watch_quiet(input string name, input logic [31:0] exp_res);
      int pulses;
      int busy_cnt;
      pulses = 0;
      busy_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (dif.result_valid !== 1'b0) pulses++;
         if (dif.busy !== 1'b0) busy_cnt++;
      end
      check({name, " no_pulse"}, pulses, 0);
      check({name, " stays_idle"}, busy_cnt, 0);
      check({name, " result_kept"}, dif.result, exp_res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      dif.start_e = 1'b0;
      dif.div_op  = OP_DIV;
      dif.src_a   = '0;
      dif.src_b   = '0;
      dif.flush_e = 1'b0;

      vecs.push_back('{"div_100_7",       OP_DIV,  32'd100,        32'd7,          32'd14,         34});
      vecs.push_back('{"rem_m100_7",      OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  34});
      vecs.push_back('{"remu_ffff_16",    OP_REMU, 32'hFFFF_FFFF,  32'd16,         32'd15,         34});
      vecs.push_back('{"divu_5_0",        OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
      vecs.push_back('{"rem_5_0",         OP_REM,  32'd5,          32'd0,          32'd5,          1});
      vecs.push_back('{"div_ovf",         OP_DIV,  INT_MIN,        32'hFFFF_FFFF,  INT_MIN,        1});
      vecs.push_back('{"rem_ovf",         OP_REM,  INT_MIN,        32'hFFFF_FFFF,  32'd0,          1});
      vecs.push_back('{"divu_max_max",    OP_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          34});
      vecs.push_back('{"div_m100_7",      OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  34});
      vecs.push_back('{"remu_big",        OP_REMU, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34});
      vecs.push_back('{"rem_7_m2",        OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34});
      vecs.push_back('{"div_0_5",         OP_DIV,  32'd0,          32'd5,          32'd0,          34});
      vecs.push_back('{"divu_min_3",      OP_DIVU, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  34});

      #12;
      check("reset busy", dif.busy, 0);
      check("reset result_valid", dif.result_valid, 0);
      check("reset result", dif.result, 0);
      check("reset stall_req", dif.stall_req, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
         end_op(vecs[i].name, vecs[i].exp);
      end

      // Back-to-back: second op issues from IDLE on the cycle right after DONE.
      run_op("b2b_divu_20_0", OP_DIVU, 32'd20, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("b2b_div_20_6", OP_DIV, 32'd20, 32'd6, 32'd3, 34);
      end_op("b2b_div_20_6", 32'd3);

      // Flush during CALC iteration 10.
      @(posedge clk); #1;
      dif.start_e = 1'b1;
      dif.div_op  = OP_DIV;
      dif.src_a   = 32'd1234;
      dif.src_b   = 32'd5;
      repeat (11) @(posedge clk);
      #1;
      check("flush busy_before", dif.busy, 1);
      dif.flush_e = 1'b1;
      @(negedge clk);
      check("flush valid_during", dif.result_valid, 0);
      @(posedge clk); #1;
      dif.flush_e = 1'b0;
      dif.start_e = 1'b0;
      watch_quiet("flush", 32'd3);
      run_op("after_flush_div_9_3", OP_DIV, 32'd9, 32'd3, 32'd3, 34);
      end_op("after_flush_div_9_3", 32'd3);

      // Asynchronous reset mid-CALC.
      @(posedge clk); #1;
      dif.start_e = 1'b1;
      dif.div_op  = OP_DIVU;
      dif.src_a   = 32'd1000;
      dif.src_b   = 32'd7;
      repeat (5) @(posedge clk);
      #1;
      check("rst busy_before", dif.busy, 1);
      rst_n = 1'b0;
      dif.start_e = 1'b0;
      #1;
      check("rst busy_now", dif.busy, 0);
      check("rst valid_now", dif.result_valid, 0);
      check("rst result_now", dif.result, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      watch_quiet("post_rst", 32'd0);
      run_op("post_rst_divu_77_7", OP_DIVU, 32'd77, 32'd7, 32'd11, 34);
      end_op("post_rst_divu_77_7", 32'd11);

      // Same operands and signedness repeat; unsigned variant never matches a signed entry.
      run_op("cache_div_1000_33", OP_DIV, 32'd1000, 32'd33, 32'd30, 34);
      end_op("cache_div_1000_33", 32'd30);
      run_op("cache_rem_1000_33", OP_REM, 32'd1000, 32'd33, 32'd10, REPEAT_LAT);
      end_op("cache_rem_1000_33", 32'd10);
      run_op("cache_divu_1000_33", OP_DIVU, 32'd1000, 32'd33, 32'd30, 34);
      end_op("cache_divu_1000_33", 32'd30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
